// File: rtl/neo_video_out.sv
// Neo-Geo video output stage: palette word to 8-bit RGB with dark/shadow handling,
// plus blanking and DE regenerated from LSPC syncs, all delayed by the same two pixels.
module neo_video_out #(
  parameter int H_START   = 28,
  parameter int H_ACTIVE  = 320,
  parameter int V_START   = 16,
  parameter int V_ACTIVE  = 224,
  parameter bit BLANK_RGB = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLK_EN_PIX,
  input  logic [15:0] PAL_DATA,
  input  logic        SHADOW,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        DE
);

  localparam logic [9:0] H_LO = 10'(H_START);
  localparam logic [9:0] H_HI = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_START);
  localparam logic [9:0] V_HI = 10'(V_START + V_ACTIVE);

  logic [8:0]  h_cnt, v_cnt;
  logic        prev_hs, prev_vs, frame_ok;
  logic        hfall, vfall, h_act, v_act;
  logic [15:0] pal_s0;
  logic        sh_s0, hs_s0, vs_s0, hact_s0, vact_s0, de_next;

  assign hfall   = prev_hs & ~HSYNC_IN;
  assign vfall   = prev_vs & ~VSYNC_IN;
  assign h_act   = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
  assign v_act   = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
  assign de_next = hact_s0 & vact_s0;

  // 4-bit channel plus shared LSB, minus dark (clamped at 0), expanded to 8 bits.
  function automatic logic [7:0] conv(input logic [3:0] x, input logic l,
                                      input logic dark, input logic sh);
    logic [5:0] v6, c6;
    logic [6:0] s7;
    logic [7:0] c8;
    v6 = {x, l, x[3]};
    s7 = {1'b0, v6} - {6'b0, dark};
    c6 = s7[6] ? 6'd0 : s7[5:0];
    c8 = {c6, c6[4:3]};
    return sh ? {1'b0, c8[7:1]} : c8;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_hs  <= 1'b1;
      prev_vs  <= 1'b1;
      h_cnt    <= '0;
      v_cnt    <= '0;
      frame_ok <= 1'b0;
    end else if (CLK_EN_PIX) begin
      prev_hs <= HSYNC_IN;
      prev_vs <= VSYNC_IN;
      if (hfall)               h_cnt <= '0;
      else if (h_cnt != 9'd511) h_cnt <= h_cnt + 9'd1;
      if (vfall)                        v_cnt <= '0;
      else if (hfall && v_cnt != 9'd511) v_cnt <= v_cnt + 9'd1;
      if (vfall) frame_ok <= 1'b1;
    end
  end

  // Stage 0: capture inputs and activity decoded from pre-update counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pal_s0  <= '0;
      sh_s0   <= 1'b0;
      hs_s0   <= 1'b1;
      vs_s0   <= 1'b1;
      hact_s0 <= 1'b0;
      vact_s0 <= 1'b0;
    end else if (CLK_EN_PIX) begin
      pal_s0  <= PAL_DATA;
      sh_s0   <= SHADOW;
      hs_s0   <= HSYNC_IN;
      vs_s0   <= VSYNC_IN;
      hact_s0 <= h_act & frame_ok;
      vact_s0 <= v_act & frame_ok;
    end
  end

  // Stage 1: registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RED    <= '0;
      GREEN  <= '0;
      BLUE   <= '0;
      HSYNC  <= 1'b1;
      VSYNC  <= 1'b1;
      HBLANK <= 1'b1;
      VBLANK <= 1'b1;
      DE     <= 1'b0;
    end else if (CLK_EN_PIX) begin
      if (BLANK_RGB && !de_next) begin
        RED   <= '0;
        GREEN <= '0;
        BLUE  <= '0;
      end else begin
        RED   <= conv(pal_s0[11:8], pal_s0[14], pal_s0[15], sh_s0);
        GREEN <= conv(pal_s0[7:4],  pal_s0[13], pal_s0[15], sh_s0);
        BLUE  <= conv(pal_s0[3:0],  pal_s0[12], pal_s0[15], sh_s0);
      end
      HSYNC  <= hs_s0;
      VSYNC  <= vs_s0;
      HBLANK <= ~hact_s0;
      VBLANK <= ~vact_s0;
      DE     <= de_next;
    end
  end

endmodule

// File: tb/tb_neo_video_out.sv
// Directed bench for neo_video_out: colour vector table plus line/frame timing sequences.
module tb_neo_video_out;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CLK_EN_PIX = 1'b0;
  logic [15:0] PAL_DATA = '0;
  logic        SHADOW = 1'b0;
  logic        HSYNC_IN = 1'b1;
  logic        VSYNC_IN = 1'b1;
  logic [7:0]  RED, GREEN, BLUE;
  logic        HSYNC, VSYNC, HBLANK, VBLANK, DE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  neo_video_out dut (
    .CLK(CLK), .RESET(RESET), .CLK_EN_PIX(CLK_EN_PIX), .PAL_DATA(PAL_DATA),
    .SHADOW(SHADOW), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .DE(DE)
  );

  typedef struct {
    logic [15:0] pal;
    logic        sh;
    logic [7:0]  r, g, b;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One pixel enable, one CLK wide; returns on a falling edge with outputs settled.
  task automatic en();
    @(negedge CLK) CLK_EN_PIX = 1'b1;
    @(negedge CLK) CLK_EN_PIX = 1'b0;
  endtask

  task automatic line(input int len);
    HSYNC_IN = 1'b0;
    en();
    HSYNC_IN = 1'b1;
    repeat (len - 1) en();
  endtask

  task automatic frame_start();
    VSYNC_IN = 1'b0;
    en();
    VSYNC_IN = 1'b1;
    repeat (16) line(5);
  endtask

  task automatic full_line(output int first, output int last, output int cnt, output int hs_bad);
    logic prev;
    prev = HSYNC_IN;
    first = -1; last = -1; cnt = 0; hs_bad = 0;
    for (int i = 0; i < 384; i++) begin
      HSYNC_IN = (i < 8) ? 1'b0 : 1'b1;
      en();
      if (DE === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (HSYNC !== prev) hs_bad++;
      prev = HSYNC_IN;
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {3'b0, RED, GREEN, BLUE, HSYNC, VSYNC, HBLANK, VBLANK, DE};
  endfunction

  initial begin
    int first, last, cnt, hs_bad, bad, vlow, vfirst, vlast;
    logic [31:0] snap;

    tv[0]  = '{16'h0F00, 1'b0, 8'hF7, 8'h00, 8'h00};
    tv[1]  = '{16'h4F00, 1'b0, 8'hFF, 8'h00, 8'h00};
    tv[2]  = '{16'h8F00, 1'b0, 8'hF3, 8'h00, 8'h00};
    tv[3]  = '{16'h8000, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[4]  = '{16'h4F00, 1'b1, 8'h7F, 8'h00, 8'h00};
    tv[5]  = '{16'h00F0, 1'b0, 8'h00, 8'hF7, 8'h00};
    tv[6]  = '{16'h2000, 1'b0, 8'h00, 8'h08, 8'h00};
    tv[7]  = '{16'h800F, 1'b0, 8'h00, 8'h00, 8'hF3};
    tv[8]  = '{16'hFFFF, 1'b0, 8'hFB, 8'hFB, 8'hFB};
    tv[9]  = '{16'h7FFF, 1'b1, 8'h7F, 8'h7F, 8'h7F};
    tv[10] = '{16'h0F00, 1'b1, 8'h7B, 8'h00, 8'h00};

    // Reset with random inputs, then three quiet enables after release.
    for (int k = 0; k < 5; k++) begin
      PAL_DATA = 16'($urandom); SHADOW = 1'($urandom);
      HSYNC_IN = 1'($urandom);  VSYNC_IN = 1'($urandom);
      en();
      chk($sformatf("reset outs %0d", k), pack_out(), 32'h0000001E);
    end
    HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      PAL_DATA = 16'($urandom);
      en();
      chk($sformatf("post reset outs %0d", k), pack_out(), 32'h0000001E);
    end

    // Line timing on an active line.
    frame_start();
    full_line(first, last, cnt, hs_bad);
    chk("de count", cnt, 320);
    chk("de first", first, 30);
    chk("de last", last, 349);
    chk("hsync delay", hs_bad, 0);

    // Colour vectors inside the active area of the next line.
    HSYNC_IN = 1'b0; en(); HSYNC_IN = 1'b1;
    PAL_DATA = '0;
    repeat (39) en();
    for (int k = 0; k < 11; k++) begin
      PAL_DATA = tv[k].pal; SHADOW = tv[k].sh;
      en(); en();
      chk($sformatf("vec%0d red", k),   RED,   tv[k].r);
      chk($sformatf("vec%0d green", k), GREEN, tv[k].g);
      chk($sformatf("vec%0d blue", k),  BLUE,  tv[k].b);
    end
    PAL_DATA = 16'h7FFF; SHADOW = 1'b0;
    repeat (300) en();
    chk("blank de", DE, 0);
    chk("blank rgb", {RED, GREEN, BLUE}, 0);
    repeat (21) en();

    // HSYNC missing: counter saturates, no return to the active window.
    HSYNC_IN = 1'b0; en(); HSYNC_IN = 1'b1;
    bad = 0; cnt = 0;
    for (int i = 1; i <= 600; i++) begin
      en();
      if (DE === 1'b1) cnt++;
      if (i >= 352 && (HBLANK !== 1'b1 || DE !== 1'b0)) bad++;
    end
    chk("sat de count", cnt, 320);
    chk("sat hblank", bad, 0);

    // Enable held off mid-line: outputs frozen while inputs wiggle.
    HSYNC_IN = 1'b0; en(); HSYNC_IN = 1'b1;
    PAL_DATA = 16'h0F00; SHADOW = 1'b0;
    repeat (99) en();
    snap = pack_out();
    chk("hold de before", DE, 1);
    chk("hold red before", RED, 8'hF7);
    PAL_DATA = 16'h7FFF; SHADOW = 1'b1; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    repeat (50) @(negedge CLK);
    chk("hold outputs", pack_out(), snap);
    PAL_DATA = 16'h0F00; SHADOW = 1'b0; HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;

    // Reset mid-line: DE stays low until a new frame starts.
    @(negedge CLK) RESET = 1'b1;
    #1;
    chk("midreset de", DE, 0);
    chk("midreset hblank", HBLANK, 1);
    @(negedge CLK) RESET = 1'b0;
    repeat (16) line(5);
    full_line(first, last, cnt, hs_bad);
    chk("no frame de", cnt, 0);
    frame_start();
    full_line(first, last, cnt, hs_bad);
    chk("new frame de count", cnt, 320);
    chk("new frame de first", first, 30);

    // Vertical window over a 264-line frame of short lines.
    vlow = 0; vfirst = -1; vlast = -1;
    for (int n = 0; n < 264; n++) begin
      if (n == 0) begin
        VSYNC_IN = 1'b0; en(); VSYNC_IN = 1'b1;
      end else begin
        HSYNC_IN = 1'b0; en(); HSYNC_IN = 1'b1;
      end
      repeat (3) en();
      if (VBLANK === 1'b0) begin
        vlow++;
        if (vfirst < 0) vfirst = n;
        vlast = n;
      end
      repeat (4) en();
    end
    chk("vblank low lines", vlow, 224);
    chk("vblank first line", vfirst, 16);
    chk("vblank last line", vlast, 239);

    // Simultaneous H/V fall must leave v_cnt at 0.
    HSYNC_IN = 1'b0; VSYNC_IN = 1'b0; en();
    HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;
    repeat (7) en();
    for (int n = 1; n <= 16; n++) begin
      HSYNC_IN = 1'b0; en(); HSYNC_IN = 1'b1;
      repeat (3) en();
      if (n == 15) chk("hv fall line15 vblank", VBLANK, 1);
      if (n == 16) chk("hv fall line16 vblank", VBLANK, 0);
      repeat (4) en();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
